// File: rtl/imsic_msi_receiver_if.sv
// AXI4 bus bundle between the APLIC-side master and the IMSIC MSI receiver.
// Signal names carry the receiver's direction prefix (i_ into it, o_ out of it).
interface imsic_msi_receiver_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4
);
    logic                        i_awvalid;
    logic                        o_awready;
    logic [AXI_ADDR_WIDTH-1:0]   i_awaddr;
    logic [AXI_ID_WIDTH-1:0]     i_awid;
    logic [7:0]                  i_awlen;

    logic                        i_wvalid;
    logic                        o_wready;
    logic [AXI_DATA_WIDTH-1:0]   i_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] i_wstrb;
    logic                        i_wlast;

    logic                        o_bvalid;
    logic                        i_bready;
    logic [AXI_ID_WIDTH-1:0]     o_bid;
    logic [1:0]                  o_bresp;

    logic                        i_arvalid;
    logic                        o_arready;
    logic [AXI_ID_WIDTH-1:0]     i_arid;
    logic [7:0]                  i_arlen;

    logic                        o_rvalid;
    logic                        i_rready;
    logic [AXI_ID_WIDTH-1:0]     o_rid;
    logic [AXI_DATA_WIDTH-1:0]   o_rdata;
    logic [1:0]                  o_rresp;
    logic                        o_rlast;

    modport slave (
        input  i_awvalid, i_awaddr, i_awid, i_awlen,
        output o_awready,
        input  i_wvalid, i_wdata, i_wstrb, i_wlast,
        output o_wready,
        output o_bvalid, o_bid, o_bresp,
        input  i_bready,
        input  i_arvalid, i_arid, i_arlen,
        output o_arready,
        output o_rvalid, o_rid, o_rdata, o_rresp, o_rlast,
        input  i_rready
    );

    modport master (
        output i_awvalid, i_awaddr, i_awid, i_awlen,
        input  o_awready,
        output i_wvalid, i_wdata, i_wstrb, i_wlast,
        input  o_wready,
        input  o_bvalid, o_bid, o_bresp,
        output i_bready,
        output i_arvalid, i_arid, i_arlen,
        input  o_arready,
        input  o_rvalid, o_rid, o_rdata, o_rresp, o_rlast,
        output i_rready
    );
endinterface

// File: rtl/imsic_msi_receiver.sv
// AXI4 write slave decoding seteipnum_le MSI writes into (file, EIID) pairs,
// buffered in a small FIFO; reads and malformed writes complete with SLVERR.
module imsic_msi_receiver #(
    parameter int unsigned NR_SRC         = 32,
    parameter int unsigned NR_INTP_FILES  = 3,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned NR_SRC_LEN    = $clog2(NR_SRC),
    localparam int unsigned FILE_LEN      = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
    input  logic                  i_clk,
    input  logic                  ni_rst,
    imsic_msi_receiver_if.slave   bus,
    output logic                  o_msi_valid,
    output logic [FILE_LEN-1:0]   o_msi_file,
    output logic [NR_SRC_LEN-1:0] o_msi_eiid,
    input  logic                  i_msi_ready
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t                 wstate_q;
    logic [AXI_ID_WIDTH-1:0] awid_q;
    logic [7:0]              awlen_q;
    logic [7:0]              beat_q;
    logic [FILE_LEN-1:0]     file_q;
    logic                    pushable_q;
    logic [1:0]              bresp_q;

    rstate_t                 rstate_q;
    logic [AXI_ID_WIDTH-1:0] arid_q;
    logic [7:0]              arlen_q;
    logic [7:0]              rbeat_q;

    logic [FILE_LEN-1:0]     fifo_file_q [FIFO_DEPTH];
    logic [NR_SRC_LEN-1:0]   fifo_eiid_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    fifo_full;
    logic                    w_hs;
    logic                    push, pop;
    logic [31:0]             eiid_w;
    logic                    eiid_ok;
    logic [FILE_LEN-1:0]     aw_file;
    logic                    aw_addr_ok;

    // Address classification happens at AW so the W path only needs one flag.
    assign aw_file    = bus.i_awaddr[12 +: FILE_LEN];
    assign aw_addr_ok = (bus.i_awaddr[11:0] == '0)
                     && (32'(aw_file) < NR_INTP_FILES)
                     && (bus.i_awaddr[AXI_ADDR_WIDTH-1:12+FILE_LEN] == '0);

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

    assign bus.o_awready = (wstate_q == W_IDLE);
    assign bus.o_wready  = (wstate_q == W_DATA) && !(pushable_q && fifo_full);
    assign bus.o_bvalid  = (wstate_q == W_RESP);
    assign bus.o_bid     = awid_q;
    assign bus.o_bresp   = bresp_q;

    assign w_hs    = bus.i_wvalid && bus.o_wready;
    assign eiid_w  = bus.i_wdata[31:0];
    assign eiid_ok = (eiid_w != '0) && (eiid_w < 32'(NR_SRC));
    assign push    = w_hs && pushable_q && (bus.i_wstrb[3:0] == 4'hF) && eiid_ok;
    assign pop     = o_msi_valid && i_msi_ready;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wstate_q   <= W_IDLE;
            awid_q     <= '0;
            awlen_q    <= '0;
            beat_q     <= '0;
            file_q     <= '0;
            pushable_q <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (bus.i_awvalid) begin
                        awid_q     <= bus.i_awid;
                        awlen_q    <= bus.i_awlen;
                        file_q     <= aw_file;
                        pushable_q <= aw_addr_ok && (bus.i_awlen == 8'd0);
                        beat_q     <= '0;
                        wstate_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        // Termination is by beat count; wlast is not trusted.
                        if (beat_q == awlen_q) begin
                            bresp_q  <= pushable_q ? RESP_OKAY : RESP_SLVERR;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.i_bready) begin
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign bus.o_arready = (rstate_q == R_IDLE);
    assign bus.o_rvalid  = (rstate_q == R_DATA);
    assign bus.o_rid     = arid_q;
    assign bus.o_rdata   = '0;
    assign bus.o_rresp   = bus.o_rvalid ? RESP_SLVERR : RESP_OKAY;
    assign bus.o_rlast   = bus.o_rvalid && (rbeat_q == arlen_q);

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rstate_q <= R_IDLE;
            arid_q   <= '0;
            arlen_q  <= '0;
            rbeat_q  <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (bus.i_arvalid) begin
                        arid_q   <= bus.i_arid;
                        arlen_q  <= bus.i_arlen;
                        rbeat_q  <= '0;
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.i_rready) begin
                        if (rbeat_q == arlen_q) begin
                            rstate_q <= R_IDLE;
                        end else begin
                            rbeat_q <= rbeat_q + 8'd1;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_file_q[i] <= '0;
                fifo_eiid_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_file_q[wptr_q] <= file_q;
                fifo_eiid_q[wptr_q] <= eiid_w[NR_SRC_LEN-1:0];
                wptr_q              <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign o_msi_valid = (count_q != '0);
    assign o_msi_file  = fifo_file_q[rptr_q];
    assign o_msi_eiid  = fifo_eiid_q[rptr_q];

    logic unused_bits;
    assign unused_bits = ^{bus.i_wlast, bus.i_wdata, bus.i_wstrb};
endmodule

// File: tb/tb_imsic_msi_receiver.sv
// Directed self-checking bench for imsic_msi_receiver.
module tb_imsic_msi_receiver;
    logic       clk;
    logic       rst_n;
    logic       msi_valid;
    logic [1:0] msi_file;
    logic [4:0] msi_eiid;
    logic       msi_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [6:0]  popped [$];

    imsic_msi_receiver_if #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(4)
    ) bus ();

    imsic_msi_receiver #(
        .NR_SRC(32),
        .NR_INTP_FILES(3),
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(4),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk),
        .ni_rst(rst_n),
        .bus(bus),
        .o_msi_valid(msi_valid),
        .o_msi_file(msi_file),
        .o_msi_eiid(msi_eiid),
        .i_msi_ready(msi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop log: ready only changes just after a rising edge, so the
    // negedge view matches what the next rising edge will see.
    always @(negedge clk) begin
        if (rst_n && msi_valid && msi_ready) begin
            popped.push_back({msi_file, msi_eiid});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [63:0] data, input logic [7:0] strb,
                             output logic [1:0] resp, output logic [3:0] bid);
        bit done;
        resp = 2'bxx;
        bid  = 4'bxxxx;
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = addr;
        bus.i_awid    = id;
        bus.i_awlen   = len;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.o_awready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.i_awvalid = 1'b0;
        if (!done) begin
            check("aw_handshake", 0, 1);
            return;
        end
        for (int b = 0; b <= int'(len); b++) begin
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = data;
            bus.i_wstrb  = strb;
            bus.i_wlast  = (b == int'(len));
            done = 0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if (bus.o_wready) begin
                    @(posedge clk); #1;
                    done = 1;
                end
            end
            if (!done) begin
                bus.i_wvalid = 1'b0;
                check("w_handshake", 0, 1);
                return;
            end
        end
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        check("b_latency", bus.o_bvalid, 1);
        bus.i_bready = 1'b1;
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.o_bvalid) begin
                resp = bus.o_bresp;
                bid  = bus.o_bid;
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.i_bready = 1'b0;
        if (!done) check("b_handshake", 0, 1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [7:0] len);
        bit done;
        int beats;
        bus.i_arvalid = 1'b1;
        bus.i_arid    = id;
        bus.i_arlen   = len;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.o_arready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.i_arvalid = 1'b0;
        if (!done) begin
            check("ar_handshake", 0, 1);
            return;
        end
        bus.i_rready = 1'b1;
        beats = 0;
        done  = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.o_rvalid) begin
                check("r_data", bus.o_rdata, 0);
                check("r_resp", bus.o_rresp, 2);
                check("r_id",   bus.o_rid, 64'(id));
                check("r_last", bus.o_rlast, (beats == int'(len)) ? 1 : 0);
                if (bus.o_rlast) done = 1;
                beats++;
                @(posedge clk); #1;
            end
        end
        bus.i_rready = 1'b0;
        check("r_beats", 64'(beats), 64'(len) + 1);
    endtask

    logic [1:0] resp;
    logic [3:0] bid;

    initial begin
        rst_n = 1'b0;
        msi_ready = 1'b0;
        bus.i_awvalid = 1'b0; bus.i_awaddr = '0; bus.i_awid = '0; bus.i_awlen = '0;
        bus.i_wvalid = 1'b0;  bus.i_wdata = '0;  bus.i_wstrb = '0; bus.i_wlast = 1'b0;
        bus.i_bready = 1'b0;
        bus.i_arvalid = 1'b0; bus.i_arid = '0; bus.i_arlen = '0;
        bus.i_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.o_awready, 1);
        check("rst_arready", bus.o_arready, 1);
        check("rst_wready",  bus.o_wready, 0);
        check("rst_bvalid",  bus.o_bvalid, 0);
        check("rst_rvalid",  bus.o_rvalid, 0);
        check("rst_rlast",   bus.o_rlast, 0);
        check("rst_bresp",   bus.o_bresp, 0);
        check("rst_rresp",   bus.o_rresp, 0);
        check("rst_bid",     bus.o_bid, 0);
        check("rst_rid",     bus.o_rid, 0);
        check("rst_rdata",   bus.o_rdata, 0);
        check("rst_msi_valid", msi_valid, 0);
        check("rst_msi_file",  msi_file, 0);
        check("rst_msi_eiid",  msi_eiid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single MSI to file 1, EIID 5
        axi_write(64'h1000, 4'd2, 8'd0, 64'd5, 8'hFF, resp, bid);
        check("single_bresp", resp, 0);
        check("single_bid", bid, 2);
        check("single_valid", msi_valid, 1);
        check("single_file", msi_file, 1);
        check("single_eiid", msi_eiid, 5);
        popped.delete();
        msi_ready = 1'b1;
        @(posedge clk); #1;
        msi_ready = 1'b0;
        check("single_popped_n", 64'(popped.size()), 1);
        if (popped.size() == 1) check("single_popped", popped[0], {2'd1, 5'd5});
        check("single_empty", msi_valid, 0);

        // EIID 0 and EIID == NR_SRC are dropped but acknowledged
        axi_write(64'h0, 4'd1, 8'd0, 64'd0, 8'hFF, resp, bid);
        check("eiid0_bresp", resp, 0);
        check("eiid0_empty", msi_valid, 0);
        axi_write(64'h0, 4'd1, 8'd0, 64'd32, 8'hFF, resp, bid);
        check("eiid32_bresp", resp, 0);
        check("eiid32_empty", msi_valid, 0);
        // Partial strobe is also dropped
        axi_write(64'h0, 4'd1, 8'd0, 64'd3, 8'h07, resp, bid);
        check("strb_bresp", resp, 0);
        check("strb_empty", msi_valid, 0);

        // Bad addresses
        axi_write(64'h1004, 4'd7, 8'd0, 64'd5, 8'hFF, resp, bid);
        check("offs_bresp", resp, 2);
        check("offs_bid", bid, 7);
        check("offs_empty", msi_valid, 0);
        axi_write(64'h3000, 4'd6, 8'd0, 64'd5, 8'hFF, resp, bid);
        check("file3_bresp", resp, 2);
        check("file3_empty", msi_valid, 0);
        axi_write(64'h1_0000_1000, 4'd6, 8'd0, 64'd5, 8'hFF, resp, bid);
        check("upper_bresp", resp, 2);
        check("upper_empty", msi_valid, 0);

        // Burst of 4 beats
        axi_write(64'h0, 4'd9, 8'd3, 64'd4, 8'hFF, resp, bid);
        check("burst_bresp", resp, 2);
        check("burst_bid", bid, 9);
        check("burst_empty", msi_valid, 0);

        // Back-pressure: four fill the FIFO, fifth stalls until a pop
        popped.delete();
        for (int k = 1; k <= 4; k++) begin
            axi_write(64'h0, 4'(k), 8'd0, 64'(k), 8'hFF, resp, bid);
            check("bp_bresp", resp, 0);
        end
        check("bp_head", msi_eiid, 1);
        fork
            begin
                axi_write(64'h0, 4'd5, 8'd0, 64'd5, 8'hFF, resp, bid);
                check("bp5_bresp", resp, 0);
                check("bp5_bid", bid, 5);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("bp_wready_low", bus.o_wready, 0);
                check("bp_bvalid_low", bus.o_bvalid, 0);
                @(posedge clk); #1;
                msi_ready = 1'b1;
            end
        join
        for (int c = 0; c < 50 && popped.size() < 5; c++) @(posedge clk);
        #1;
        check("bp_popped_n", 64'(popped.size()), 5);
        for (int k = 0; k < 5 && k < popped.size(); k++) begin
            check("bp_order", popped[k], {2'd0, 5'(k + 1)});
        end

        // Read with a concurrent MSI write
        popped.delete();
        fork
            axi_read(4'd3, 8'd1);
            begin
                axi_write(64'h2000, 4'd4, 8'd0, 64'd7, 8'hFF, resp, bid);
                check("rw_bresp", resp, 0);
                check("rw_bid", bid, 4);
            end
        join
        repeat (3) @(posedge clk); #1;
        check("rw_popped_n", 64'(popped.size()), 1);
        if (popped.size() == 1) check("rw_popped", popped[0], {2'd2, 5'd7});
        msi_ready = 1'b0;

        // Reset mid-transaction
        axi_write(64'h1000, 4'd1, 8'd0, 64'd9, 8'hFF, resp, bid);
        check("pre_rst_valid", msi_valid, 1);
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 64'h0;
        bus.i_awlen   = 8'd0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.i_awvalid = 1'b0;
        check("mid_wready", bus.o_wready, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wready", bus.o_wready, 0);
        check("mid_rst_awready", bus.o_awready, 1);
        check("mid_rst_valid", msi_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_bvalid", bus.o_bvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
